// File: rtl/voice_mixer.sv
// Multi-oscillator voice mixer: level-weighted sum of NUM_OSC signed samples through one
// shared multiplier, scaled by an envelope gain, with optional 16-bit saturation.
module voice_mixer #(
  parameter int NUM_OSC  = 4,
  parameter int SATURATE = 1
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   sample_tick,
  input  logic [16*NUM_OSC-1:0]  osc_in,
  input  logic [16*NUM_OSC-1:0]  level_in,
  input  logic [15:0]            env_in,
  output logic [15:0]            out,
  output logic                   out_valid,
  output logic                   busy,
  output logic                   clip,
  output logic                   overrun
);

  localparam int IW = (NUM_OSC > 1) ? $clog2(NUM_OSC) : 1;
  localparam int AW = 17 + $clog2(NUM_OSC);
  localparam int PW = AW + 17;
  localparam int YW = AW + 1;

  typedef enum logic [1:0] {IDLE, ACC, ENV, DONE} state_t;

  state_t                 state_q, state_d;
  logic [16*NUM_OSC-1:0]  osc_q, osc_d, level_q, level_d;
  logic [15:0]            env_q, env_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [15:0]            out_q, out_d;
  logic                   clip_q, clip_d;
  logic                   out_valid_q, out_valid_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;

  logic signed [AW-1:0]   mul_a_s;
  logic signed [16:0]     mul_b_s;
  logic signed [PW-1:0]   prod_s;
  logic signed [YW-1:0]   y_s;
  logic                   y_in_range_s;

  // Shared multiplier: oscillator x level while accumulating, accumulator x envelope in ENV.
  always_comb begin
    if (state_q == ENV) begin
      mul_a_s = acc_q;
      mul_b_s = $signed({1'b0, env_q});
    end else begin
      mul_a_s = AW'($signed(osc_q[{idx_q, 4'b0000} +: 16]));
      mul_b_s = $signed({1'b0, level_q[{idx_q, 4'b0000} +: 16]});
    end
    prod_s       = PW'(mul_a_s) * PW'(mul_b_s);
    y_s          = YW'(prod_s >>> 16);
    y_in_range_s = (&y_s[YW-1:15]) | ~(|y_s[YW-1:15]);
  end

  // Next-state and datapath updates for the IDLE/ACC/ENV/DONE sequence.
  always_comb begin
    state_d     = state_q;
    osc_d       = osc_q;
    level_d     = level_q;
    env_d       = env_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_d       = out_q;
    clip_d      = clip_q;
    out_valid_d = 1'b0;
    overrun_d   = sample_tick && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          osc_d   = osc_in;
          level_d = level_in;
          env_d   = env_in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        // Each term fits in 17 bits, so truncating y_s to the accumulator width is lossless.
        acc_d = acc_q + AW'(y_s);
        if (idx_q == IW'(NUM_OSC - 1)) begin
          idx_d   = '0;
          state_d = ENV;
        end else begin
          idx_d   = idx_q + IW'(1);
        end
      end
      ENV: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (SATURATE != 0) begin
          if (y_in_range_s) begin
            out_d  = y_s[15:0];
            clip_d = 1'b0;
          end else begin
            out_d  = y_s[YW-1] ? 16'h8000 : 16'h7FFF;
            clip_d = 1'b1;
          end
        end else begin
          out_d  = y_s[15:0];
          clip_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      osc_q       <= '0;
      level_q     <= '0;
      env_q       <= 16'h0000;
      acc_q       <= '0;
      idx_q       <= '0;
      out_q       <= 16'h0000;
      clip_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      osc_q       <= osc_d;
      level_q     <= level_d;
      env_q       <= env_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      clip_q      <= clip_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out       = out_q;
  assign clip      = clip_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Scoreboard bench for voice_mixer: a saturating and a wrapping instance share stimulus,
// expectations come from a plain-arithmetic model and are checked by per-instance monitors.
module tb_voice_mixer;

  localparam int N = 4;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic            sample_tick = 1'b0;
  logic [16*N-1:0] osc_in = '0;
  logic [16*N-1:0] level_in = '0;
  logic [15:0]     env_in = 16'h0000;

  logic [15:0] out_s, out_w;
  logic        out_valid_s, out_valid_w, busy_s, busy_w, clip_s, clip_w, overrun_s, overrun_w;

  voice_mixer #(.NUM_OSC(N), .SATURATE(1)) dut_s (
    .Clk(Clk), .Reset_n(Reset_n), .sample_tick(sample_tick), .osc_in(osc_in),
    .level_in(level_in), .env_in(env_in), .out(out_s), .out_valid(out_valid_s),
    .busy(busy_s), .clip(clip_s), .overrun(overrun_s));

  voice_mixer #(.NUM_OSC(N), .SATURATE(0)) dut_w (
    .Clk(Clk), .Reset_n(Reset_n), .sample_tick(sample_tick), .osc_in(osc_in),
    .level_in(level_in), .env_in(env_in), .out(out_w), .out_valid(out_valid_w),
    .busy(busy_w), .clip(clip_w), .overrun(overrun_w));

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] out;
    logic        clip;
    int          tcyc;
  } exp_t;

  exp_t q_s[$];
  exp_t q_w[$];
  int total = 0;
  int bad   = 0;
  int ov_s_cnt = 0;
  int ov_w_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: sum of floor(osc*level/65536), then floor(acc*env/65536), in wide integers.
  function automatic longint calc_y(input logic [16*N-1:0] o, input logic [16*N-1:0] l,
                                    input logic [15:0] e);
    longint acc = 0;
    for (int i = 0; i < N; i++) begin
      longint ov = longint'($signed(o[16*i +: 16]));
      longint lv = longint'(l[16*i +: 16]);
      acc += (ov * lv) >>> 16;
    end
    return (acc * longint'(e)) >>> 16;
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 4))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Saturating-instance monitor.
  exp_t        e_s;
  logic [15:0] hold_out_s = 16'h0000;
  logic        hold_clip_s = 1'b0;
  always @(negedge Clk) begin
    if (!Reset_n) begin
      hold_out_s  <= 16'h0000;
      hold_clip_s <= 1'b0;
    end else if (out_valid_s) begin
      if (q_s.size() == 0) begin
        check("unexpected_valid_s", 32'd1, 32'd0);
      end else begin
        e_s = q_s.pop_front();
        check("out_s", 32'(out_s), 32'(e_s.out));
        check("clip_s", 32'(clip_s), 32'(e_s.clip));
        check("latency_s", 32'(cyc - e_s.tcyc), 32'(N + 2));
        hold_out_s  <= e_s.out;
        hold_clip_s <= e_s.clip;
      end
    end else begin
      check("hold_out_s", 32'(out_s), 32'(hold_out_s));
      check("hold_clip_s", 32'(clip_s), 32'(hold_clip_s));
    end
    if (overrun_s) ov_s_cnt <= ov_s_cnt + 1;
  end

  // Wrapping-instance monitor.
  exp_t        e_w;
  logic [15:0] hold_out_w = 16'h0000;
  always @(negedge Clk) begin
    if (!Reset_n) begin
      hold_out_w <= 16'h0000;
    end else if (out_valid_w) begin
      if (q_w.size() == 0) begin
        check("unexpected_valid_w", 32'd1, 32'd0);
      end else begin
        e_w = q_w.pop_front();
        check("out_w", 32'(out_w), 32'(e_w.out));
        check("clip_w", 32'(clip_w), 32'(e_w.clip));
        check("latency_w", 32'(cyc - e_w.tcyc), 32'(N + 2));
        hold_out_w <= e_w.out;
      end
    end else begin
      check("hold_out_w", 32'(out_w), 32'(hold_out_w));
      check("hold_clip_w", 32'(clip_w), 32'd0);
    end
    if (overrun_w) ov_w_cnt <= ov_w_cnt + 1;
  end

  task automatic send(input logic [16*N-1:0] o, input logic [16*N-1:0] l, input logic [15:0] e,
                      input logic [15:0] eo_s, input logic ec_s, input logic [15:0] eo_w);
    exp_t x;
    @(negedge Clk);
    osc_in      = o;
    level_in    = l;
    env_in      = e;
    sample_tick = 1'b1;
    x.tcyc = cyc;
    x.out  = eo_s;
    x.clip = ec_s;
    q_s.push_back(x);
    x.out  = eo_w;
    x.clip = 1'b0;
    q_w.push_back(x);
    @(negedge Clk);
    sample_tick = 1'b0;
  endtask

  task automatic send_model(input logic [16*N-1:0] o, input logic [16*N-1:0] l,
                            input logic [15:0] e);
    longint      y;
    logic [63:0] yb;
    logic [15:0] eo_s;
    logic        ec_s;
    y  = calc_y(o, l, e);
    yb = y;
    if (y > 32767) begin
      eo_s = 16'h7FFF; ec_s = 1'b1;
    end else if (y < -32768) begin
      eo_s = 16'h8000; ec_s = 1'b1;
    end else begin
      eo_s = yb[15:0]; ec_s = 1'b0;
    end
    send(o, l, e, eo_s, ec_s, yb[15:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    logic [16*N-1:0] ro, rl;
    int ov0_s, ov0_w, waited;

    repeat (3) @(negedge Clk);
    check("rst_out", 32'(out_s), 32'd0);
    check("rst_valid", 32'(out_valid_s), 32'd0);
    check("rst_busy", 32'(busy_s), 32'd0);
    check("rst_clip", 32'(clip_s), 32'd0);
    check("rst_overrun", 32'(overrun_s), 32'd0);
    Reset_n = 1'b1;
    idle(2);

    // Single active oscillator at half level, half envelope.
    send({16'h0000, 16'h0000, 16'h0000, 16'h1000}, {16'h0000, 16'h0000, 16'h0000, 16'h8000},
         16'h8000, 16'h0400, 1'b0, 16'h0400);
    check("busy_in_acc", 32'(busy_s), 32'd1);
    idle(6);
    check("busy_back_idle", 32'(busy_s), 32'd0);

    // Positive overflow: y = 65531.
    send({N{16'h4000}}, {N{16'hFFFF}}, 16'hFFFF, 16'h7FFF, 1'b1, 16'hFFFB);
    idle(5);
    // Negative overflow: y = -131070; minimum spacing back-to-back.
    send({N{16'h8000}}, {N{16'hFFFF}}, 16'hFFFF, 16'h8000, 1'b1, 16'h0002);
    idle(5);
    send_model({N{16'hC000}}, {16'h1234, 16'hFFFF, 16'h0001, 16'h8000}, 16'hFFFF);
    idle(8);

    // Tick while busy: ignored, overrun once, snapshot protects the result.
    ov0_s = ov_s_cnt;
    ov0_w = ov_w_cnt;
    for (int i = 0; i < N; i++) begin
      ro[16*i +: 16] = rand16();
      rl[16*i +: 16] = rand16();
    end
    send_model(ro, rl, rand16());
    osc_in   = ~ro;
    level_in = ~rl;
    @(negedge Clk);
    sample_tick = 1'b1;
    @(negedge Clk);
    sample_tick = 1'b0;
    idle(8);
    check("overrun_once_s", 32'(ov_s_cnt - ov0_s), 32'd1);
    check("overrun_once_w", 32'(ov_w_cnt - ov0_w), 32'd1);
    check("queue_empty_after_overrun", 32'(q_s.size() + q_w.size()), 32'd0);

    // Reset mid-computation: aborted, no result; next tick computes afresh.
    send_model({N{16'h7FFF}}, {N{16'h4000}}, 16'hFFFF);
    idle(2);
    #2 Reset_n = 1'b0;
    #1;
    check("abort_out_s", 32'(out_s), 32'd0);
    check("abort_busy_s", 32'(busy_s), 32'd0);
    check("abort_valid_s", 32'(out_valid_s), 32'd0);
    check("abort_out_w", 32'(out_w), 32'd0);
    void'(q_s.pop_back());
    void'(q_w.pop_back());
    idle(2);
    Reset_n = 1'b1;
    idle(10);
    send_model({16'h0100, 16'hFF00, 16'h7FFF, 16'h8001}, {N{16'hA000}}, 16'hC000);
    idle(8);

    // Randomized traffic at legal spacing.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) begin
        ro[16*i +: 16] = rand16();
        rl[16*i +: 16] = rand16();
      end
      send_model(ro, rl, rand16());
      osc_in = 16*N'($urandom);
      idle($urandom_range(5, 10));
    end

    waited = 0;
    while ((q_s.size() != 0 || q_w.size() != 0) && waited < 50) begin
      @(negedge Clk);
      waited++;
    end
    check("drain_s", 32'(q_s.size()), 32'd0);
    check("drain_w", 32'(q_w.size()), 32'd0);
    check("overrun_total_s", 32'(ov_s_cnt), 32'd1);
    check("overrun_total_w", 32'(ov_w_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
VOICE_MIXER -- requirements
Module: voice_mixer

Interface
REQ-001 SHALL have parameter NUM_OSC, default 4, number of oscillator inputs mixed (legal 2..8).
REQ-002 SHALL have parameter SATURATE, default 1, where 1 = clamp final result to 16-bit signed and 0 = wrap (keep low 16 bits).
REQ-003 SHALL have port Clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sample_tick  input  1  one-cycle pulse starting one mix computation.
REQ-006 SHALL have port osc_in  input  16*NUM_OSC  signed oscillator samples, osc i at bits [16i+15:16i].
REQ-007 SHALL have port level_in  input  16*NUM_OSC  unsigned Q0.16 per-oscillator levels, same packing.
REQ-008 SHALL have port env_in  input  16  unsigned Q0.16 envelope gain.
REQ-009 SHALL have port out  output  16  signed mixed sample.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse when out updates.
REQ-011 SHALL have port busy  output  1  high while a computation is in progress.
REQ-012 SHALL have port clip  output  1  qualified by out_valid; high when the result was saturated.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when sample_tick arrives while busy.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, ENV, DONE.
REQ-015 IDLE: on sample_tick, SHALL snapshot osc_in, level_in and env_in into registers, clear the accumulator and index, and enter ACC.
REQ-016 ACC: SHALL process one oscillator per cycle (index 0..NUM_OSC-1) through a single shared multiplier, then enter ENV after index NUM_OSC-1.
REQ-017 Per-oscillator term SHALL be p_i = (osc_i * level_i) >>> 16, with osc signed, level zero-extended unsigned, and arithmetic shift (floor).
REQ-018 Accumulator SHALL be signed, 17+clog2(NUM_OSC) bits wide, and SHALL never overflow internally.
REQ-019 ENV: SHALL compute y = (acc * env) >>> 16, with env zero-extended unsigned and floor rounding, in one cycle, then enter DONE.
REQ-020 DONE: SHALL register out = sat16(y) if SATURATE=1, else y[15:0]; assert out_valid for this one cycle; and return to IDLE.
REQ-021 clip SHALL be 1 exactly when SATURATE=1 and y lies outside [-32768, 32767]; it SHALL be 0 otherwise, including always when SATURATE=0.
REQ-022 Latency SHALL be NUM_OSC+2 cycles from sample_tick sampled high to out_valid high.
REQ-023 A new sample_tick SHALL be accepted in the cycle after out_valid (DONE to IDLE); the minimum tick spacing is NUM_OSC+3 cycles.
REQ-024 busy SHALL be high in ACC, ENV and DONE, and low in IDLE.
REQ-025 sample_tick while busy SHALL be ignored (computation neither restarts nor aborts) and SHALL pulse overrun in the next cycle.
REQ-026 Input changes after the snapshot SHALL NOT affect the computation in progress.
REQ-027 out and clip SHALL hold their values between out_valid pulses.

Reset
REQ-028 Reset_n low SHALL immediately, asynchronously, force state IDLE, out=0, out_valid=0, busy=0, clip=0, overrun=0, accumulator=0 and index=0.
REQ-029 Reset asserted mid-computation SHALL abort it with no out_valid pulse; the first sample_tick after deassertion SHALL start a fresh computation.

Verification
REQ-030 NUM_OSC=4: osc0=0x1000, level0=0x8000, all other levels 0, env=0x8000, tick -> out=0x0400, clip=0, out_valid exactly 6 cycles after tick.
REQ-031 NUM_OSC=4, SATURATE=1: all osc=0x4000, all levels=0xFFFF, env=0xFFFF -> y=65531, out=0x7FFF, clip=1.
REQ-032 Same stimulus as REQ-031 with SATURATE=0 -> out=0xFFFB, clip=0.
REQ-033 All osc=0x8000, all levels=0xFFFF, env=0xFFFF, SATURATE=1 -> y=-131070, out=0x8000, clip=1.
REQ-034 Tick, then a second tick 2 cycles later -> overrun pulses once, exactly one out_valid, first result unchanged; osc_in changed after the first tick -> out still reflects the snapshot values.
REQ-035 Reset_n pulsed low 3 cycles after tick -> no out_valid, out=0, busy=0; a tick after release -> correct result after NUM_OSC+2 cycles.
